// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Contents: memory geometry, requester port indices and the request
// record that the top uses to carry the winning port's fields.
package dmem_pkg;

  localparam int DMEM_DEPTH  = 1024;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  // Fields of one requester, as presented to the memory when granted.
  typedef struct packed {
    logic                   wen;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2: two-way grant logic with a remembered last winner.
// Ports:
//   clock      in  rising-edge clock
//   rst_n      in  synchronous active-low reset (last winner -> port 1)
//   req_valid  in  [1:0] per-port request
//   grant      out [1:0] one-hot (or zero) combinational grant
// RR_EN=1 alternates on contention; RR_EN=0 always favours port 0.
// Any grant outside reset is an acceptance (the top only raises ready
// on a grant), so the last winner is updated directly from the grant.
module rr_arbiter2 #(
  parameter int RR_EN = 1
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant selection from the current requests and the previous winner.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if ((RR_EN != 0) && (last_grant_q == 1'b0)) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
  end

  // Next last-winner: reset makes port 0 win the first contest.
  always_comb begin
    last_grant_d = last_grant_q;
    if (!rst_n) begin
      last_grant_d = 1'b1;
    end else if (grant[1]) begin
      last_grant_d = 1'b1;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-winner register.
  always_ff @(posedge clock) begin
    last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU data
// port (port 0) and the loader/debug port (port 1).
// Ports:
//   clock, rst_n            clock and synchronous active-low reset
//   req_valid/wen/addr/wdata per-port request (port i in slice i)
//   req_ready               per-port accept, at most one bit high
//   rsp_valid/rdata/err     registered response, one cycle after accept
//   mem_addr/wen/wdata      drive to the memory (write on the clock edge)
//   mem_rdata               combinational read data from the memory
//   grant_cnt0/1            saturating accepted-request counters
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int RR_EN  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_wen,
  input  logic [2*ADDR_W-1:0]    req_addr,
  input  logic [63:0]            req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_wen,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [CNT_W-1:0]       grant_cnt0,
  output logic [CNT_W-1:0]       grant_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]             grant_s;
  logic                   accept_s;
  logic                   in_range_s;
  dmem_req_t              sel_req_s;

  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [DMEM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]       cnt0_q,      cnt0_d;
  logic [CNT_W-1:0]       cnt1_q,      cnt1_d;

  rr_arbiter2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .grant     (grant_s)
  );

  // Ready is the grant, suppressed in reset; ready bits are the transfers.
  assign req_ready = rst_n ? grant_s : 2'b00;
  assign accept_s  = |req_ready;

  // Pick the accepted port's fields; idle cycles drive zeros.
  always_comb begin
    sel_req_s = '0;
    if (req_ready[PORT_DBG]) begin
      sel_req_s.wen   = req_wen[PORT_DBG];
      sel_req_s.addr  = DMEM_ADDR_W'(req_addr[PORT_DBG*ADDR_W +: ADDR_W]);
      sel_req_s.wdata = req_wdata[PORT_DBG*DMEM_DATA_W +: DMEM_DATA_W];
    end else if (req_ready[PORT_CPU]) begin
      sel_req_s.wen   = req_wen[PORT_CPU];
      sel_req_s.addr  = DMEM_ADDR_W'(req_addr[PORT_CPU*ADDR_W +: ADDR_W]);
      sel_req_s.wdata = req_wdata[PORT_CPU*DMEM_DATA_W +: DMEM_DATA_W];
    end else begin
      sel_req_s = '0;
    end
  end

  assign in_range_s = (sel_req_s.addr < DMEM_ADDR_W'(DEPTH));
  assign mem_addr   = ADDR_W'(sel_req_s.addr);
  assign mem_wdata  = sel_req_s.wdata;
  // Out-of-range writes are answered with an error and never reach memory.
  assign mem_wen    = accept_s & sel_req_s.wen & in_range_s;

  // Response and counter next-state.
  always_comb begin
    rsp_valid_d = 2'b00;
    rsp_rdata_d = 32'h0000_0000;
    rsp_err_d   = 1'b0;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (!rst_n) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      rsp_valid_d = req_ready;
      rsp_err_d   = accept_s & ~in_range_s;
      // Read data is captured at acceptance, before any later write lands.
      if (accept_s && !sel_req_s.wen && in_range_s) begin
        rsp_rdata_d = mem_rdata;
      end else begin
        rsp_rdata_d = 32'h0000_0000;
      end
      if (req_ready[PORT_CPU] && (cnt0_q != CNT_MAX)) begin
        cnt0_d = cnt0_q + CNT_ONE;
      end else begin
        cnt0_d = cnt0_q;
      end
      if (req_ready[PORT_DBG] && (cnt1_q != CNT_MAX)) begin
        cnt1_d = cnt1_q + CNT_ONE;
      end else begin
        cnt1_d = cnt1_q;
      end
    end
  end

  // Response and counter registers.
  always_ff @(posedge clock) begin
    rsp_valid_q <= rsp_valid_d;
    rsp_rdata_q <= rsp_rdata_d;
    rsp_err_q   <= rsp_err_d;
    cnt0_q      <= cnt0_d;
    cnt1_q      <= cnt1_d;
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances share one stimulus stream.
//   dut a: round-robin, 4-bit counters; dut b: fixed priority, 16-bit.
// Each has its own memory; a per-cycle reference model predicts every
// output from the request rules, plus directed literal expectations.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_wen;
  logic [63:0] req_addr, req_wdata;

  logic [1:0]  req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
  logic [31:0] rsp_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [31:0] rsp_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        rsp_err_a, mem_wen_a, rsp_err_b, mem_wen_b;
  logic [3:0]  grant_cnt0_a, grant_cnt1_a;
  logic [15:0] grant_cnt0_b, grant_cnt1_b;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  int checks   = 0;
  int failures = 0;

  // reference model state, index 0 = dut a, 1 = dut b
  logic [31:0] m_mem [2][1024];
  logic [1:0]  e_rv [2];
  logic [31:0] e_rd [2];
  logic        e_err [2];
  int          e_c0 [2];
  int          e_c1 [2];
  int          m_last [2];
  bit          m_live = 1'b0;
  logic [31:0] mem0_init;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(32), .DEPTH(1024), .RR_EN(1), .CNT_W(4)) u_dut_a (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .mem_addr(mem_addr_a), .mem_wen(mem_wen_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .grant_cnt0(grant_cnt0_a), .grant_cnt1(grant_cnt1_a));

  dmem_arbiter #(.ADDR_W(32), .DEPTH(1024), .RR_EN(0), .CNT_W(16)) u_dut_b (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .mem_addr(mem_addr_b), .mem_wen(mem_wen_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .grant_cnt0(grant_cnt0_b), .grant_cnt1(grant_cnt1_b));

  // environment memories: combinational read, write on the edge
  assign mem_rdata_a = (mem_addr_a < 32'd1024) ? mem_a[mem_addr_a[9:0]] : 32'hBAD0_BAD0;
  assign mem_rdata_b = (mem_addr_b < 32'd1024) ? mem_b[mem_addr_b[9:0]] : 32'hBAD0_BAD0;

  always @(posedge clock) begin
    if (mem_wen_a) mem_a[mem_addr_a[9:0]] <= mem_wdata_a;
    if (mem_wen_b) mem_b[mem_addr_b[9:0]] <= mem_wdata_b;
  end

  task automatic check(input string nm, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // One cycle of the reference model: compare, then advance past the edge.
  task automatic model_cycle(input int k);
    logic [1:0]  a_ready, a_rv, x_ready;
    logic        a_wen, a_err, x_wen, inr;
    logic [31:0] a_maddr, a_mwdata, a_rd;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    int          a_c0, a_c1, g, maxc;
    if (k == 0) begin
      a_ready = req_ready_a; a_rv = rsp_valid_a; a_wen = mem_wen_a; a_err = rsp_err_a;
      a_maddr = mem_addr_a; a_mwdata = mem_wdata_a; a_rd = rsp_rdata_a;
      a_c0 = int'(grant_cnt0_a); a_c1 = int'(grant_cnt1_a);
    end else begin
      a_ready = req_ready_b; a_rv = rsp_valid_b; a_wen = mem_wen_b; a_err = rsp_err_b;
      a_maddr = mem_addr_b; a_mwdata = mem_wdata_b; a_rd = rsp_rdata_b;
      a_c0 = int'(grant_cnt0_b); a_c1 = int'(grant_cnt1_b);
    end
    ad[0] = req_addr[31:0];  ad[1] = req_addr[63:32];
    wd[0] = req_wdata[31:0]; wd[1] = req_wdata[63:32];
    maxc = (k == 0) ? 15 : 65535;
    // winner of this cycle: the lone requester, or on contention the port
    // that did not win last time (dut a) / port 0 (dut b)
    g = -1;
    if (rst_n === 1'b1) begin
      if (req_valid == 2'b11) g = (k == 0) ? (1 - m_last[k]) : 0;
      else if (req_valid[0]) g = 0;
      else if (req_valid[1]) g = 1;
    end
    x_ready = 2'b00;
    if (g == 0) x_ready = 2'b01;
    else if (g == 1) x_ready = 2'b10;
    inr   = (g >= 0) && (ad[g] < 32'd1024);
    x_wen = (g >= 0) && req_wen[g] && inr;
    if (m_live) begin
      check("req_ready", k, a_ready, x_ready);
      check("mem_wen", k, a_wen, x_wen);
      if (g >= 0) begin
        check("mem_addr", k, a_maddr, ad[g]);
        check("mem_wdata", k, a_mwdata, wd[g]);
      end else if (rst_n) begin
        check("mem_addr_idle", k, a_maddr, 32'h0);
        check("mem_wdata_idle", k, a_mwdata, 32'h0);
      end
      check("rsp_valid", k, a_rv, e_rv[k]);
      check("rsp_rdata", k, a_rd, e_rd[k]);
      check("rsp_err", k, a_err, e_err[k]);
      check("grant_cnt0", k, a_c0, e_c0[k]);
      check("grant_cnt1", k, a_c1, e_c1[k]);
    end
    if (!rst_n) begin
      e_rv[k] = 2'b00; e_rd[k] = 32'h0; e_err[k] = 1'b0;
      e_c0[k] = 0; e_c1[k] = 0; m_last[k] = 1;
    end else begin
      e_rv[k]  = x_ready;
      e_err[k] = (g >= 0) && !inr;
      e_rd[k]  = 32'h0;
      if (g >= 0) begin
        if (!req_wen[g] && inr) e_rd[k] = m_mem[k][ad[g][9:0]];
        if (x_wen) m_mem[k][ad[g][9:0]] = wd[g];
        if (g == 0) e_c0[k] = (e_c0[k] == maxc) ? maxc : e_c0[k] + 1;
        else        e_c1[k] = (e_c1[k] == maxc) ? maxc : e_c1[k] + 1;
        m_last[k] = g;
      end
    end
  endtask

  // compare process: every falling edge, both instances
  initial begin
    forever begin
      @(negedge clock);
      model_cycle(0);
      model_cycle(1);
      if (!rst_n) m_live = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v; req_wen = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 99) < 10) return 32'd1020 + 32'($urandom_range(0, 10));
    return 32'($urandom_range(0, 15));
  endfunction

  logic [1:0] acc_both;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m_mem[0][i] = $urandom;
      if (i == 5) m_mem[0][i] = 32'hDEAD_BEEF;
      m_mem[1][i] = m_mem[0][i];
      mem_a[i] <= m_mem[0][i];
      mem_b[i] <= m_mem[0][i];
    end
    mem0_init = m_mem[0][0];
    rst_n = 1'b0;
    set_req(2'b11, 2'b11, 32'd3, 32'd4, 32'h1111_1111, 32'h2222_2222);

    // reset held with both requesting writes
    repeat (3) cyc();
    #2;
    check("rst_ready", 0, req_ready_a, 2'b00);
    check("rst_ready", 1, req_ready_b, 2'b00);
    check("rst_mem_wen", 0, mem_wen_a, 1'b0);
    check("rst_rsp_valid", 0, rsp_valid_a, 2'b00);
    check("rst_cnt0", 0, grant_cnt0_a, 4'd0);
    check("rst_cnt1", 1, grant_cnt1_b, 16'd0);

    // contention for 4 cycles: a alternates from port 0, b stays on port 0
    for (int i = 0; i < 4; i++) begin
      cyc();
      rst_n = 1'b1;
      set_req(2'b11, 2'b00, 32'd1, 32'd2, 32'h0, 32'h0);
      #2;
      check("contend_ready", 0, req_ready_a, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("contend_ready", 1, req_ready_b, 2'b01);
    end
    cyc();
    set_req(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check("contend_cnt0", 0, grant_cnt0_a, 4'd2);
    check("contend_cnt1", 0, grant_cnt1_a, 4'd2);
    check("contend_cnt0", 1, grant_cnt0_b, 16'd4);
    check("contend_cnt1", 1, grant_cnt1_b, 16'd0);

    // single read of addr 5
    cyc();
    set_req(2'b01, 2'b00, 32'd5, 32'h0, 32'h0, 32'h0);
    #2;
    check("read_ready", 0, req_ready_a, 2'b01);
    cyc();
    set_req(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check("read_rsp_valid", 0, rsp_valid_a, 2'b01);
    check("read_rdata", 0, rsp_rdata_a, 32'hDEAD_BEEF);
    check("read_err", 0, rsp_err_a, 1'b0);

    // port 0 writes addr 10, port 1 reads it back the next cycle
    cyc();
    set_req(2'b01, 2'b01, 32'd10, 32'h0, 32'h1234_5678, 32'h0);
    #2;
    check("wr_mem_wen", 0, mem_wen_a, 1'b1);
    check("wr_mem_addr", 0, mem_addr_a, 32'd10);
    cyc();
    set_req(2'b10, 2'b00, 32'h0, 32'd10, 32'h0, 32'h0);
    #2;
    check("wr_rsp_valid", 0, rsp_valid_a, 2'b01);
    check("wr_rdata", 0, rsp_rdata_a, 32'h0);
    cyc();
    set_req(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check("raw_rsp_valid", 0, rsp_valid_a, 2'b10);
    check("raw_rdata", 0, rsp_rdata_a, 32'h1234_5678);
    check("raw_rdata", 1, rsp_rdata_b, 32'h1234_5678);

    // out-of-range write from port 1
    cyc();
    set_req(2'b10, 2'b10, 32'h0, 32'd1024, 32'h0, 32'hCAFE_F00D);
    #2;
    check("oor_mem_wen", 0, mem_wen_a, 1'b0);
    check("oor_ready", 0, req_ready_a, 2'b10);
    cyc();
    set_req(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check("oor_rsp_valid", 0, rsp_valid_a, 2'b10);
    check("oor_err", 0, rsp_err_a, 1'b1);
    check("oor_rdata", 0, rsp_rdata_a, 32'h0);
    check("oor_cnt1", 0, grant_cnt1_a, 4'd4);
    check("oor_mem_kept", 0, mem_a[0], mem0_init);

    // 20 more port-0 reads: 4-bit counter saturates
    for (int i = 0; i < 20; i++) begin
      cyc();
      set_req(2'b01, 2'b00, 32'(i), 32'h0, 32'h0, 32'h0);
    end
    cyc();
    set_req(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check("sat_cnt0", 0, grant_cnt0_a, 4'd15);
    check("sat_cnt0", 1, grant_cnt0_b, 16'd26);

    // reset right after an accepted read drops the following response
    cyc();
    set_req(2'b01, 2'b00, 32'd7, 32'h0, 32'h0, 32'h0);
    #2;
    check("rdrop_ready", 0, req_ready_a, 2'b01);
    cyc();
    rst_n = 1'b0;
    #2;
    check("rdrop_rsp_now", 0, rsp_valid_a, 2'b01);
    check("rdrop_ready_rst", 0, req_ready_a, 2'b00);
    cyc();
    #2;
    check("rdrop_rsp_valid", 0, rsp_valid_a, 2'b00);
    check("rdrop_cnt0", 0, grant_cnt0_a, 4'd0);
    check("rdrop_cnt1", 0, grant_cnt1_a, 4'd0);
    cyc();
    rst_n = 1'b1;
    set_req(2'b11, 2'b00, 32'd1, 32'd2, 32'h0, 32'h0);
    #2;
    check("rdrop_first_win", 0, req_ready_a, 2'b01);

    // randomized traffic; a waiting request keeps its fields
    acc_both = req_ready_a & req_ready_b;
    for (int n = 0; n < 400; n++) begin
      cyc();
      for (int p = 0; p < 2; p++) begin
        if (!(rst_n && req_valid[p] && !acc_both[p])) begin
          req_valid[p]           = ($urandom_range(0, 3) != 0);
          req_wen[p]             = ($urandom_range(0, 1) != 0);
          req_addr[p*32 +: 32]   = rand_addr();
          req_wdata[p*32 +: 32]  = $urandom;
        end
      end
      rst_n = ($urandom_range(0, 59) != 0);
      #2;
      acc_both = req_ready_a & req_ready_b;
    end

    cyc();
    rst_n = 1'b1;
    set_req(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
